// File: rtl/i2c_sda_in_pio_pkg.sv
// Shared definitions for the I2C SDA input PIO: register map, edge-type
// encodings and a constant clog2 helper.
package i2c_sda_in_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 32'sd0;
  localparam int EDGE_FALL = 32'sd1;
  localparam int EDGE_ANY  = 32'sd2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/i2c_sda_in_pio_if.sv
// Avalon-MM slave register bus of the SDA input PIO; readdata is driven by
// the slave with zero wait states.
interface i2c_sda_in_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/i2c_sda_in_pio_glitch_filter.sv
// Single-bit pin conditioner: two-flop synchroniser, stable-count glitch
// filter and edge detector feeding the capture register.
module pio_glitch_filter
  import i2c_sda_in_pio_pkg::*;
#(
  parameter int   FILTER_CYCLES = 3,
  parameter int   EDGE_TYPE     = EDGE_ANY,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_filt,
  output logic o_edge
);

  localparam int CNT_W = (clog2(FILTER_CYCLES + 1) > 1) ? clog2(FILTER_CYCLES + 1) : 1;

  logic r_s1;
  logic r_s2;
  logic r_filt_d;
  logic w_filt;
  logic w_rise;
  logic w_fall;
  logic w_edge;

  // two-flop synchroniser on the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= RESET_LEVEL;
      r_s2 <= RESET_LEVEL;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign w_filt = r_s2;
    end else begin : g_filter
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
      logic             r_filt;
      logic [CNT_W-1:0] r_cnt;

      // filtered value only follows s2 after FILTER_CYCLES consecutive differing samples
      always_ff @(posedge clk) begin
        if (reset) begin
          r_filt <= RESET_LEVEL;
          r_cnt  <= {CNT_W{1'b0}};
        end else if (r_s2 == r_filt) begin
          r_cnt  <= {CNT_W{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
          r_filt <= r_s2;
          r_cnt  <= {CNT_W{1'b0}};
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
        end
      end

      assign w_filt = r_filt;
    end
  endgenerate

  // one-cycle delayed copy for edge detection; reset matches filt so reset makes no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt_d <= RESET_LEVEL;
    end else begin
      r_filt_d <= w_filt;
    end
  end

  // edge select
  always_comb begin
    w_rise = w_filt & ~r_filt_d;
    w_fall = ~w_filt & r_filt_d;
    case (EDGE_TYPE)
      EDGE_RISE: w_edge = w_rise;
      EDGE_FALL: w_edge = w_fall;
      EDGE_ANY:  w_edge = w_rise | w_fall;
      default:   w_edge = w_rise | w_fall;
    endcase
  end

  assign o_filt = w_filt;
  assign o_edge = w_edge;

endmodule

// File: rtl/i2c_sda_in_pio.sv
// Avalon-MM input PIO for the software I2C driver: filtered pin readback,
// sticky edge capture with write-1-to-clear, and a masked level interrupt.
module i2c_sda_in_pio
  import i2c_sda_in_pio_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               FILTER_CYCLES = 3,
  parameter int               EDGE_TYPE     = EDGE_ANY,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  i2c_sda_in_pio_if.slave  bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_edgecap_nxt;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      w_readdata;
  logic             w_wr;
  logic             w_unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_glitch_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .EDGE_TYPE     (EDGE_TYPE),
        .RESET_LEVEL   (RESET_LEVEL[gi])
      ) u_filter (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (in_port[gi]),
        .o_filt (w_filt[gi]),
        .o_edge (w_edge[gi])
      );
    end
  endgenerate

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_unused_wdata = ^bus.writedata;

  // capture next-state: a fresh edge beats a simultaneous clear
  always_comb begin
    if (w_wr && (bus.address == ADDR_EDGECAP)) begin
      w_clear = bus.writedata[WIDTH-1:0];
    end else begin
      w_clear = {WIDTH{1'b0}};
    end
    w_edgecap_nxt = (r_edgecap & ~w_clear) | w_edge;
  end

  // mask and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= {WIDTH{1'b0}};
      r_edgecap <= {WIDTH{1'b0}};
    end else begin
      if (w_wr && (bus.address == ADDR_IRQMASK)) begin
        r_irqmask <= bus.writedata[WIDTH-1:0];
      end else begin
        r_irqmask <= r_irqmask;
      end
      r_edgecap <= w_edgecap_nxt;
    end
  end

  // zero-latency read mux, zero-extended
  always_comb begin
    w_readdata = 32'd0;
    case (bus.address)
      ADDR_DATA:    w_readdata[WIDTH-1:0] = w_filt;
      ADDR_RSVD:    w_readdata = 32'd0;
      ADDR_IRQMASK: w_readdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_readdata[WIDTH-1:0] = r_edgecap;
      default:      w_readdata = 32'd0;
    endcase
  end

  assign bus.readdata = w_readdata;
  assign irq          = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_i2c_sda_in_pio.sv
// Directed bench for i2c_sda_in_pio (WIDTH=1, FILTER_CYCLES=3, EDGE_TYPE=any)
// with an expectation queue drained by a negedge monitor.
module tb_i2c_sda_in_pio;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] exp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [0:0] in_port;
  logic       irq;
  logic       mon_req;
  exp_t       sb_q[$];
  int         n_pass;
  int         n_total;

  i2c_sda_in_pio_if bus ();

  i2c_sda_in_pio #(
    .WIDTH         (1),
    .FILTER_CYCLES (3),
    .EDGE_TYPE     (2),
    .RESET_LEVEL   (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: drain every queued expectation when the bench presents a sample
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (mon_req) begin
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = e.is_irq ? {31'd0, irq} : bus.readdata;
        n_total++;
        if (act === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_read(input logic [1:0] a, input logic [31:0] v, input string nm);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    sb_q.push_back('{nm, 1'b0, v});
  endtask

  task automatic exp_irq(input logic v, input string nm);
    sb_q.push_back('{nm, 1'b1, {31'd0, v}});
  endtask

  task automatic sample();
    mon_req = 1'b1;
    @(negedge clk);
    #1;
    mon_req        = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  // one-cycle write; returns just after the edge that performed it
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    mon_req        = 1'b0;
    reset          = 1'b1;
    in_port        = 1'b1;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // reset state
    tick(3);
    reset = 1'b0;
    exp_read(2'd0, 32'd1, "rst_data"); sample(); tick(1);
    exp_read(2'd1, 32'd0, "rst_rsvd"); exp_irq(1'b0, "rst_irq"); sample(); tick(1);
    exp_read(2'd2, 32'd0, "rst_mask"); sample(); tick(1);
    exp_read(2'd3, 32'd0, "rst_edgecap"); sample();

    // held falling edge: sampled at k, filt changes at k+4, capture at k+5
    in_port = 1'b0;
    tick(4);
    exp_read(2'd0, 32'd1, "fall_data_k3"); sample(); tick(1);
    exp_read(2'd0, 32'd0, "fall_data_k4"); sample(); tick(1);
    exp_read(2'd3, 32'd1, "fall_edgecap"); exp_irq(1'b0, "fall_irq_masked"); sample();
    in_port = 1'b1;
    tick(10);
    wr(2'd3, 32'd1);
    exp_read(2'd3, 32'd0, "clear_edgecap"); sample(); tick(1);
    exp_read(2'd0, 32'd1, "rise_data"); sample(); tick(1);

    // writes to DATA are ignored
    wr(2'd0, 32'd0);
    exp_read(2'd0, 32'd1, "data_ro"); sample(); tick(1);

    // 2-cycle glitch is rejected
    in_port = 1'b0;
    tick(2);
    in_port = 1'b1;
    tick(3);
    exp_read(2'd0, 32'd1, "glitch_data"); sample();
    tick(6);
    exp_read(2'd3, 32'd0, "glitch_edgecap"); sample(); tick(1);

    // 3-cycle pulse passes through
    in_port = 1'b0;
    tick(3);
    in_port = 1'b1;
    tick(12);
    exp_read(2'd3, 32'd1, "pulse_edgecap"); exp_irq(1'b0, "pulse_irq_masked"); sample(); tick(1);
    exp_read(2'd0, 32'd1, "pulse_data"); sample(); tick(1);

    // enable mask, then clear
    wr(2'd2, 32'd1);
    exp_read(2'd2, 32'd1, "mask_rd"); exp_irq(1'b1, "irq_on_mask"); sample(); tick(1);
    wr(2'd3, 32'd1);
    exp_read(2'd3, 32'd0, "w1c_edgecap"); exp_irq(1'b0, "irq_after_clear"); sample(); tick(1);

    // clear collides with a new edge: set wins
    in_port = 1'b0;
    tick(5);
    wr(2'd3, 32'd1);
    exp_read(2'd3, 32'd1, "collide_edgecap"); exp_irq(1'b1, "collide_irq"); sample();
    in_port = 1'b1;
    tick(10);
    wr(2'd3, 32'd1);
    exp_read(2'd3, 32'd0, "settle_clear"); exp_irq(1'b0, "settle_irq"); sample(); tick(1);

    // reset mid-filter (counter at 2), released with the pin still low
    in_port = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_read(2'd0, 32'd1, "midrst_data"); sample(); tick(1);
    exp_read(2'd3, 32'd0, "midrst_edgecap"); exp_irq(1'b0, "midrst_irq"); sample(); tick(1);
    exp_read(2'd2, 32'd0, "midrst_mask"); sample();
    tick(3);
    exp_read(2'd3, 32'd0, "postrst_edgecap_k4"); sample(); tick(1);
    exp_read(2'd3, 32'd1, "postrst_edgecap_k5"); sample(); tick(1);
    exp_read(2'd0, 32'd0, "postrst_data"); sample(); tick(1);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_total++;
      $display("FAIL %s: never sampled, expected %0h", e.name, e.exp);
    end

    if (n_total < 12) begin
      $display("FAIL too few checks executed: %0d", n_total);
    end else begin
      $display("check count ok: %0d", n_total);
    end

    if (n_pass != n_total) begin
      $display("FAIL %0d of %0d checks failed", n_total - n_pass, n_total);
    end else begin
      $display("PASS all checks");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
